stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and time-base stage directly upstream of the seconds-digit chain. It debounces the raw start/stop and clear buttons, runs the IDLE/RUN/PAUSE/DONE state machine and latches the count direction. It divides the board clock into a one-cycle count-enable pulse that drives the `start` input of the S0 digit. It also issues the digits' synchronous clear and stops a down-count when the display reaches zero.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count tick; must be ≥ 2.
- `DEBOUNCE_CYC`, default 1_000_000: consecutive stable cycles required to accept a button level.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state when 0.
- `btn_start` in 1: raw start/stop button, active-high, asynchronous.
- `btn_clear` in 1: raw clear button, active-high, asynchronous.
- `sw_mode` in 1: raw direction switch (1 = up, 0 = down), asynchronous.
- `all_zero` in 1: high when every downstream digit reads 0.
- `start` out 1: one-cycle count-enable pulse to the S0 digit.
- `ups` out 1: latched direction to all digits.
- `clr` out 1: one-cycle synchronous clear to all digits (active-high).
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- **Input conditioning:** every raw input passes a 2-flop synchronizer.
- **Debouncing:** each button's debounced level changes only after the synchronized value differs from it for `DEBOUNCE_CYC` consecutive cycles. Any bounce restarts the count.
- **Press event:** one cycle on the rising edge of the debounced level. Releases generate nothing.
- **Direction latch:** `ups` loads the synchronized `sw_mode` every cycle in IDLE only. It is frozen in RUN, PAUSE and DONE.
- **IDLE:**
  - Start press with `ups`=1 -> RUN.
  - Start press with `ups`=0 and `all_zero`=0 -> RUN.
  - Start press with `ups`=0 and `all_zero`=1 -> stays IDLE.
- **RUN:**
  - Start press -> PAUSE.
  - `ups`=0 and `all_zero`=1 -> DONE. This transition takes priority over a start press and over a tick in the same cycle.
- **PAUSE:** start press -> RUN.
- **DONE:** start press is ignored.
- **Clear press, any state:** -> IDLE and `clr`=1 for exactly one cycle. Clear beats start in the same cycle.
- **Prescaler:** counts 0..`TICK_DIV`-1, width `$clog2(TICK_DIV)`, and increments only in RUN.
  - At `TICK_DIV`-1 it wraps to 0 and `start` pulses.
  - Cleared to 0 in IDLE and DONE.
  - Held in PAUSE, so the fractional period is preserved across pause and resume.
- **Tick suppression:** `start` is 0 in every cycle where the state is not RUN, and in any cycle where a RUN->DONE transition is taken.

## Timing
- **Reset values:** state IDLE, `start`=0, `ups`=1, `clr`=0, `running`=0, `done`=0, prescaler 0, debounced levels 0.
- **Press latency:** a raw button rising edge that is stable from cycle 0 gives a press pulse in cycle 2+`DEBOUNCE_CYC`. The state and `clr` change at the following edge.
- **First tick:** the first `start` pulse after entering RUN from IDLE occurs `TICK_DIV` cycles after entry. The spacing between subsequent pulses is exactly `TICK_DIV` cycles.
- **Mid-operation reset:** asserting `reset` takes effect immediately (asynchronously). Release is synchronous to `clk`, and the first state change is possible no earlier than 3 cycles after release.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.

## Structure
- **Shared package `stopwatch_pkg`:**
  - `ctrl_state_t` enum with values `IDLE`, `RUN`, `PAUSE`, `DONE`.
  - Default constants `TICK_DIV_DEF` and `DEBOUNCE_CYC_DEF`.
- **Sub-module `btn_debounce`:** synchronizer, debounce counter and rising-edge detector. Instantiated twice, for start and clear.
- **Direction switch:** synchronizer only, in the top level.

## Test plan
All scenarios run with `TICK_DIV`=10 and `DEBOUNCE_CYC`=4.
1. **Reset:** hold `reset`=0 with all inputs 0 -> all outputs at their reset values. Release, wait 20 cycles -> no `start` pulse.
2. **Basic run:** `sw_mode`=1, press start -> `running`=1. `start` pulses every 10 cycles, the first 10 cycles after entering RUN. `ups`=1.
3. **Pause/resume:** press start again 7 cycles after a tick -> PAUSE with no pulses. Resume -> next pulse 3 cycles after re-entering RUN.
4. **Bounce:** toggle `btn_start` 1-0-1 within 3 cycles, then hold high -> exactly one press event and one state change.
5. **Down-count stop:** `sw_mode`=0, start, then raise `all_zero` -> DONE the next cycle, `done`=1, no `start` in that cycle. A start press is then ignored. A clear press -> `clr` high for 1 cycle and IDLE.
6. **Mode latch and collision:** toggle `sw_mode` while in RUN -> `ups` unchanged. Press start and clear in the same cycle -> IDLE with `clr` pulse.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared control-state type and default timing constants for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} ctrl_state_t;
  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int DEBOUNCE_CYC_DEF = 1_000_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debouncer and one-cycle press pulse on rising edge
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      press <= 1'b0;
      // any cycle that agrees with the accepted level restarts the stability count
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s2;
        cnt <= '0;
        press <= s2;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced buttons, IDLE/RUN/PAUSE/DONE control and count-tick prescaler
// feeding the seconds-digit chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_clear,
  input  logic sw_mode,
  input  logic all_zero,
  output logic start,
  output logic ups,
  output logic clr,
  output logic running,
  output logic done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  ctrl_state_t state;
  logic [PW-1:0] presc;
  logic mode_s1, mode_s2, start_press, clear_press;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start (
    .clk(clk), .reset(reset), .raw(btn_start), .press(start_press)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
    .clk(clk), .reset(reset), .raw(btn_clear), .press(clear_press)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      start <= 1'b0;
      ups <= 1'b1;
      clr <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      mode_s1 <= sw_mode;
      mode_s2 <= mode_s1;
      if (state == IDLE) ups <= mode_s2;
      start <= 1'b0;
      clr <= 1'b0;
      if (clear_press) begin
        state <= IDLE;
        presc <= '0;
        clr <= 1'b1;
        running <= 1'b0;
        done <= 1'b0;
      end else
        case (state)
          IDLE: begin
            presc <= '0;
            if (start_press && (ups || !all_zero)) begin
              state <= RUN;
              running <= 1'b1;
            end
          end
          RUN:
            // reaching zero on a down-count wins over both a press and a due tick
            if (!ups && all_zero) begin
              state <= DONE;
              presc <= '0;
              running <= 1'b0;
              done <= 1'b1;
            end else if (start_press) begin
              state <= PAUSE;
              running <= 1'b0;
            end else begin
              presc <= (presc == LAST) ? '0 : presc + 1'b1;
              start <= presc == LAST;
            end
          PAUSE:
            if (start_press) begin
              state <= RUN;
              running <= 1'b1;
            end
          DONE: presc <= '0;
        endcase
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of reset, run/pause timing, debounce, down-count stop and clear
module tb_stopwatch_ctrl;
  logic clk = 1'b0, reset = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, sw_mode = 1'b1, all_zero = 1'b0;
  logic start, ups, clr, running, done;
  int checks = 0, failures = 0, cyc = 0, nstart = 0, last_tick = -1;
  int e, b, c, d, f, g, h, i, j, n0;
  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear), .sw_mode(sw_mode),
    .all_zero(all_zero), .start(start), .ups(ups), .clr(clr), .running(running), .done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    if (start) begin
      nstart++;
      last_tick = cyc;
    end
  endtask
  task automatic go(input int t);
    while (cyc < t) step();
  endtask
  initial begin
    #23;
    chk("rst_start", start, 0);
    chk("rst_ups", ups, 1);
    chk("rst_clr", clr, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    go(20);
    chk("idle_no_tick", nstart, 0);
    chk("idle_not_running", running, 0);
    btn_start = 1'b1;
    go(26);
    chk("press_latency_early", running, 0);
    go(27);
    chk("press_latency", running, 1);
    e = cyc;
    btn_start = 1'b0;
    go(e + 9);
    chk("first_tick_early", nstart, 0);
    go(e + 10);
    chk("first_tick_cnt", nstart, 1);
    chk("first_tick_pulse", start, 1);
    go(e + 11);
    chk("tick_one_cycle", start, 0);
    go(e + 20);
    chk("second_tick_at", last_tick, e + 20);
    chk("ups_run", ups, 1);
    go(e + 21);
    btn_start = 1'b1;
    go(e + 27);
    chk("pre_pause_run", running, 1);
    go(e + 28);
    chk("paused", running, 0);
    btn_start = 1'b0;
    go(e + 40);
    chk("pause_no_tick", nstart, 2);
    btn_start = 1'b1;
    go(e + 47);
    chk("resumed", running, 1);
    btn_start = 1'b0;
    go(e + 49);
    chk("resume_tick_early", nstart, 2);
    go(e + 50);
    chk("resume_tick_at", last_tick, e + 50);
    b = e + 55;
    go(b);
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    btn_start = 1'b1;
    go(b + 8);
    chk("bounce_wait", running, 1);
    go(b + 9);
    chk("bounce_pause", running, 0);
    go(b + 19);
    btn_start = 1'b0;
    go(b + 30);
    chk("bounce_single_event", running, 0);
    chk("bounce_ticks", nstart, 4);
    c = b + 30;
    btn_clear = 1'b1;
    sw_mode = 1'b0;
    go(c + 6);
    chk("clr_early", clr, 0);
    go(c + 7);
    chk("clr_pulse", clr, 1);
    chk("ups_frozen_pause", ups, 1);
    btn_clear = 1'b0;
    go(c + 8);
    chk("clr_one_cycle", clr, 0);
    chk("ups_load_idle", ups, 0);
    d = c + 14;
    go(d);
    all_zero = 1'b1;
    btn_start = 1'b1;
    go(d + 8);
    chk("zero_start_blocked", running, 0);
    btn_start = 1'b0;
    go(d + 10);
    chk("zero_idle_not_done", done, 0);
    all_zero = 1'b0;
    f = d + 16;
    go(f);
    btn_start = 1'b1;
    go(f + 7);
    chk("down_run", running, 1);
    g = cyc;
    btn_start = 1'b0;
    n0 = nstart;
    go(g + 9);
    all_zero = 1'b1;
    go(g + 10);
    chk("done_set", done, 1);
    chk("done_not_running", running, 0);
    chk("done_tick_suppressed", start, 0);
    chk("done_tick_count", nstart, n0);
    go(g + 12);
    btn_start = 1'b1;
    go(g + 22);
    chk("done_ignores_start", done, 1);
    chk("done_stays_stopped", running, 0);
    btn_start = 1'b0;
    h = g + 30;
    go(h);
    btn_clear = 1'b1;
    go(h + 7);
    chk("done_clr_pulse", clr, 1);
    chk("done_cleared", done, 0);
    btn_clear = 1'b0;
    all_zero = 1'b0;
    sw_mode = 1'b1;
    i = h + 14;
    go(i);
    btn_start = 1'b1;
    go(i + 7);
    chk("mode_run", running, 1);
    btn_start = 1'b0;
    go(i + 8);
    sw_mode = 1'b0;
    go(i + 18);
    chk("ups_frozen_run", ups, 1);
    j = cyc;
    btn_start = 1'b1;
    btn_clear = 1'b1;
    go(j + 7);
    chk("collide_clr", clr, 1);
    chk("collide_idle", running, 0);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    go(j + 8);
    chk("collide_clr_once", clr, 0);
    chk("collide_ups_reload", ups, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
